// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, flag bit positions and divider state encoding
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on the partial remainder
import alu_pkg::*;
module div_step #(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q
);
  logic [W:0] shifted, diff;
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {1'b0, dvs};
    q        = ~diff[W];
    rem_next = q ? diff[W-1:0] : shifted[W-1:0];
  end
endmodule

// File: rtl/divider.sv
// divider: iterative signed/unsigned restoring divider, one quotient bit per clock
import alu_pkg::*;
module divider #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             S,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic [3:0]       Flags
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_e state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] p, a, dm, op1, m1, m2, p_next, q_fix, r_fix;
  logic neg_q, neg_r, dz, ov, q_bit, dz_in, ov_in;
  logic [3:0] f_fix;
  div_step #(.W(WIDTH)) u_step (
    .rem(p), .bit_in(a[WIDTH-1]), .dvs(dm), .rem_next(p_next), .q(q_bit)
  );
  always_comb begin
    m1    = (S & In1[WIDTH-1]) ? -In1 : In1;
    m2    = (S & In2[WIDTH-1]) ? -In2 : In2;
    dz_in = In2 == '0;
    ov_in = S & (In1 == MIN_NEG) & (In2 == '1);
    q_fix = dz ? '1 : ov ? MIN_NEG : neg_q ? -a : a;
    r_fix = dz ? op1 : ov ? '0 : neg_r ? -p : p;
    f_fix = '0;
    f_fix[FLAG_N] = q_fix[WIDTH-1];
    f_fix[FLAG_Z] = q_fix == '0;
    f_fix[FLAG_C] = dz;
    f_fix[FLAG_V] = ov;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      a     <= '0;
      dm    <= '0;
      op1   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      ov    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Quot  <= '0;
      Rem   <= '0;
      Flags <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op1   <= In1;
          a     <= m1;
          dm    <= m2;
          p     <= '0;
          cnt   <= CW'(WIDTH - 1);
          neg_q <= S & (In1[WIDTH-1] ^ In2[WIDTH-1]);
          neg_r <= S & In1[WIDTH-1];
          dz    <= dz_in;
          ov    <= ov_in;
          busy  <= 1'b1;
          state <= (dz_in | ov_in) ? FIX : RUN;
        end
        RUN: begin
          p     <= p_next;
          a     <= {a[WIDTH-2:0], q_bit};
          cnt   <= cnt - 1'b1;
          state <= (cnt == '0) ? FIX : RUN;
        end
        FIX: begin
          Quot  <= q_fix;
          Rem   <= r_fix;
          Flags <= f_fix;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and random checks of divider against an arithmetic reference
module tb_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic S = 1'b0;
  logic [31:0] In1 = '0, In2 = '0;
  logic busy, done;
  logic [31:0] Quot, Rem;
  logic [3:0] Flags;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .S(S), .In1(In1), .In2(In2),
    .busy(busy), .done(done), .Quot(Quot), .Rem(Rem), .Flags(Flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic [3:0] f, output int lat);
    int sa, sb;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; c = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; v = 1'b1;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    f = {q[31], q == 0, c, v};
    lat = (c | v) ? 1 : 33;
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit mid_start);
    logic [31:0] eq, er;
    logic [3:0] ef;
    int lat, edges, bcnt;
    model(s, a, b, eq, er, ef, lat);
    @(negedge clk);
    S = s; In1 = a; In2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    In1 = $urandom; In2 = $urandom; S = ~s;
    edges = 0;
    bcnt = busy ? 1 : 0;
    while (edges < 100) begin
      if (mid_start && edges == 10) begin start = 1'b1; In1 = $urandom; In2 = 32'd3; end
      if (edges == 11) start = 1'b0;
      @(posedge clk); #1;
      edges++;
      if (done) break;
      if (busy) bcnt++;
    end
    check("latency", 64'(edges), 64'(lat));
    check("busy_cycles", 64'(bcnt), 64'(lat));
    check("quot", {32'h0, Quot}, {32'h0, eq});
    check("rem", {32'h0, Rem}, {32'h0, er});
    check("flags", {60'h0, Flags}, {60'h0, ef});
    check("busy_in_done", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    check("done_pulse", {63'h0, done}, 64'h0);
    check("quot_held", {32'h0, Quot}, {32'h0, eq});
  endtask

  initial begin
    logic [31:0] a, b;
    int dn;
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_quot", {32'h0, Quot}, 64'h0);
    check("rst_flags", {60'h0, Flags}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 32'd7, 32'd2, 1'b0);
    do_op(1'b1, -32'sd7, 32'd2, 1'b0);
    do_op(1'b1, 32'd7, -32'sd2, 1'b0);
    do_op(1'b1, 32'd5, 32'd0, 1'b0);
    do_op(1'b0, 32'd5, 32'd0, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b0, 32'd0, 32'd30, 1'b1);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    // mid-operation reset: outputs clear at once and no done pulse follows
    do_op(1'b0, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    In1 = 32'd12345; In2 = 32'd67; S = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_quot", {32'h0, Quot}, 64'h0);
    check("arst_rem", {32'h0, Rem}, 64'h0);
    check("arst_flags", {60'h0, Flags}, 64'h0);
    check("arst_busy", {63'h0, busy}, 64'h0);
    dn = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; dn += done ? 1 : 0; end
    check("no_done_after_rst", 64'(dn), 64'h0);
    do_op(1'b0, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(1, 255));
        1: b = 0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 255));
        default: ;
      endcase
      do_op(1'($urandom), a, b, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Sequential iterative integer divider for the ALU, the inverse companion of the combinational multiplier. It accepts a dividend/divisor pair on a start pulse and runs one restoring-division step per clock. It returns quotient, remainder and a 4-bit flag vector with a done pulse. Signed or unsigned operation is selected per operation by `S`, using the same operand, `S` and `Flags` conventions as the multiplier, so the ALU mux treats both identically.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `S`  in  1  1 = signed (two's complement), 0 = unsigned; sampled with `start`
- `In1`  in  WIDTH  dividend; sampled with `start`
- `In2`  in  WIDTH  divisor; sampled with `start`
- `busy`  out  1  high from the cycle after start is accepted until done
- `done`  out  1  one-cycle pulse; results are valid from this cycle on
- `Quot`  out  WIDTH  quotient, held until next completion
- `Rem`  out  WIDTH  remainder, held until next completion
- `Flags`  out  4  {N, Z, C, V}: [3] N = Quot MSB, [2] Z = Quot==0, [1] C = divide-by-zero, [0] V = signed overflow

## Operation
- FSM states:
  - IDLE: start=1 latches operands and S.
    - Divisor == 0, or signed overflow: go to FIX.
    - Otherwise: go to RUN, iteration counter = WIDTH-1.
  - RUN: one step per cycle. Partial remainder P (WIDTH+1 bits) shifts left, taking in the next dividend MSB. Trial subtraction P − |divisor| is performed; if non-negative, P is replaced and quotient bit = 1, else quotient bit = 0. When the counter reaches 0, go to FIX.
  - FIX: apply sign correction, register Quot/Rem/Flags, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Signed mode:
  - Operate on magnitudes.
  - Quotient is negated if operand signs differ; the result truncates toward zero.
  - Remainder takes the dividend's sign.
  - Invariant: In1 == Quot*In2 + Rem.
- Divide-by-zero (In2 == 0, either mode): Quot = all ones, Rem = In1, C=1, V=0.
- Signed overflow (S=1, In1 = 0x80000000, In2 = 0xFFFFFFFF): Quot = 0x80000000, Rem = 0, V=1, C=0.
- Unsigned mode: V is always 0.
- N and Z are always computed from the final Quot, including the special cases.
- `start` while busy or in DONE: ignored, with no queuing. Operand changes after acceptance have no effect.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, Quot=0, Rem=0, Flags=0. An in-flight operation is discarded with no done pulse.
- Reset deassert: the first usable start is at the next rising edge.
- Normal operation, with the start-accepting edge as E0:
  - RUN occupies E1..E32 (WIDTH edges).
  - FIX registers results at E33.
  - done is high in the cycle after E33.
  - Start-to-done latency = WIDTH+1 edges.
- Special cases: IDLE→FIX at E0, FIX at E1, done high after E1 (latency 1 edge).
- busy is high from after E0 through the FIX cycle, and low in DONE and IDLE.
- Back-to-back operation: start may be asserted during the DONE cycle but is ignored. It is accepted on the first IDLE cycle, so the minimum issue interval is latency + 2 edges.

## Structure
- Shared package `alu_pkg`:
  - `WIDTH` default
  - flag bit indices `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V` (shared with the multiplier)
  - divider state enum {IDLE, RUN, FIX, DONE}
- One combinational sub-module `div_step`:
  - inputs: partial remainder, next dividend bit, divisor magnitude
  - outputs: next partial remainder, quotient bit
  - instantiated once and reused each RUN cycle.

## Test plan
- Unsigned 7 / 2 (S=0) → Quot=3, Rem=1, Flags=0000, done exactly 33 edges after start edge, busy high for 33 cycles.
- Signed −7 / 2 (S=1) → Quot=0xFFFFFFFD, Rem=0xFFFFFFFF, Flags=1000; also 7 / −2 → Quot=−3, Rem=1.
- Divide-by-zero 5 / 0 (S=1 and S=0) → Quot=0xFFFFFFFF, Rem=5, Flags=1010, done 1 edge after start.
- Signed overflow 0x80000000 / 0xFFFFFFFF → Quot=0x80000000, Rem=0, Flags=1001. The same operands with S=0 → Quot=0, Rem=0x80000000, Flags=0100 after 33 edges.
- Zero dividend 0 / 30 → Quot=0, Rem=0, Flags=0100. A second start pulse mid-RUN is ignored and the result is unchanged.
- rst_n pulsed low at edge E10 of an operation → outputs 0 immediately, no done pulse. A new 100 / 7 started afterwards → Quot=14, Rem=2.
